// File: rtl/line_run_detector_pkg.sv
// Shared connect-4 definitions: piece encoding, player IDs and the
// line-scanner state type used by the run detector and its helpers.
package line_run_detector_pkg;

    // Default width of one game piece; 0 is an empty cell.
    localparam int PIECE_W_DEF = 2;

    // Piece encodings.
    localparam int EMPTY_PIECE = 0;
    localparam int RED         = 1;
    localparam int YELLOW      = 2;

    // Line-scanner states, kept as plain constants so legacy blocks that
    // compare raw state bits keep working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to hold a run count from 0 up to run_len inclusive.
    function automatic int run_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/line_run_detector_run_tracker.sv
// Tracks the length of the current run of identical non-empty pieces.
// run_next is the run length that the piece on the input would produce if
// accepted this cycle; the top level uses it to detect a win at the same
// edge that the piece is accepted.
module run_tracker
    import line_run_detector_pkg::*;
#(
    parameter int PIECE_W = PIECE_W_DEF,
    parameter int RUN_LEN = 4,
    parameter int RUN_W   = run_width(RUN_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [PIECE_W-1:0] piece,
    output logic [RUN_W-1:0]   run_next
);

    logic [PIECE_W-1:0] prev;
    logic [RUN_W-1:0]   run;

    // Next run length: extend on a repeat, restart on a new player, zero on empty.
    always_comb begin
        // NOTE: default first so every path assigns run_next and no latch is inferred.
        run_next = '0;
        if (piece == PIECE_W'(EMPTY_PIECE)) begin
            run_next = '0;
        end else if (piece == prev) begin
            // A matching non-empty piece implies prev is non-empty too.
            run_next = (run == RUN_W'(RUN_LEN)) ? run : run + RUN_W'(1);
        end else begin
            run_next = RUN_W'(1);
        end
    end

    // Remember the last accepted piece and its run length.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            prev <= '0;
            run  <= '0;
        end else if (clear) begin
            prev <= '0;
            run  <= '0;
        end else if (accept) begin
            prev <= piece;
            run  <= run_next;
        end
    end

endmodule

// File: rtl/line_run_detector.sv
// Scans one line of a connect-4 board, one cell per accepted beat, and
// reports the first run of RUN_LEN identical pieces together with the
// index of its first cell. All outputs are registered.
module line_run_detector
    import line_run_detector_pkg::*;
#(
    parameter int PIECE_W = PIECE_W_DEF,
    parameter int RUN_LEN = 4,
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [PIECE_W-1:0] piece,
    output logic               in_ready,
    output logic               win,
    output logic [PIECE_W-1:0] win_player,
    output logic [IDX_W-1:0]   win_idx,
    output logic               done
);

    localparam int RUN_W = run_width(RUN_LEN);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_cell;
    logic [RUN_W-1:0] run_next;

    // A piece counts only in SCAN, and a simultaneous start takes priority.
    assign accept    = (state == ST_SCAN) && in_valid && !start;
    assign last_cell = in_last || (idx == IDX_W'(MAX_LEN - 1));

    // Both flags decode the registered state, so inputs never reach outputs.
    assign in_ready = (state == ST_SCAN);
    assign done     = (state == ST_DONE);

    run_tracker #(
        .PIECE_W (PIECE_W),
        .RUN_LEN (RUN_LEN),
        .RUN_W   (RUN_W)
    ) u_run_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .accept   (accept),
        .piece    (piece),
        .run_next (run_next)
    );

    // Line-scan control, cell index and the sticky first-win record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            win        <= 1'b0;
            win_player <= '0;
            win_idx    <= '0;
        end else if (start) begin
            // Start from any state opens a fresh line; an unfinished line is dropped.
            state      <= ST_SCAN;
            idx        <= '0;
            win        <= 1'b0;
            win_player <= '0;
            win_idx    <= '0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (in_valid) begin
                        if (idx != IDX_W'(MAX_LEN - 1)) begin
                            idx <= idx + IDX_W'(1);
                        end
                        if (!win && (run_next == RUN_W'(RUN_LEN))) begin
                            win        <= 1'b1;
                            win_player <= piece;
                            win_idx    <= idx - IDX_W'(RUN_LEN - 1);
                        end
                        if (last_cell) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_run_detector.sv
// Self-checking bench: three detector instances (default, long line, short
// run) share one stimulus stream; each is compared every cycle against a
// line-buffer model that searches the accepted cells for the first run.
module tb_line_run_detector;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_last;
    logic [1:0] piece;

    logic       rdy0, win0, done0;
    logic [1:0] pl0;
    logic [2:0] wi0;
    logic       rdy1, win1, done1;
    logic [1:0] pl1;
    logic [3:0] wi1;
    logic       rdy2, win2, done2;
    logic [1:0] pl2;
    logic [2:0] wi2;

    int total = 0;
    int bad   = 0;

    // Model: per instance, phase (0 idle, 1 scan, 2 done) and accepted cells.
    int rl[3] = '{4, 4, 3};
    int ml[3] = '{8, 16, 8};
    int m_phase[3];
    int m_n[3];
    int m_cells[3][16];

    line_run_detector #(.PIECE_W(2), .RUN_LEN(4), .MAX_LEN(8)) u_def (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_last(in_last), .piece(piece), .in_ready(rdy0), .win(win0),
        .win_player(pl0), .win_idx(wi0), .done(done0)
    );

    line_run_detector #(.PIECE_W(2), .RUN_LEN(4), .MAX_LEN(16)) u_long (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_last(in_last), .piece(piece), .in_ready(rdy1), .win(win1),
        .win_player(pl1), .win_idx(wi1), .done(done1)
    );

    line_run_detector #(.PIECE_W(2), .RUN_LEN(3), .MAX_LEN(8)) u_short (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_last(in_last), .piece(piece), .in_ready(rdy2), .win(win2),
        .win_player(pl2), .win_idx(wi2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Start of the earliest window of rl[k] equal non-empty cells, or -1.
    function automatic int first_run(input int k);
        for (int s = 0; s + rl[k] <= m_n[k]; s++) begin
            bit same = (m_cells[k][s] != 0);
            for (int j = 1; j < rl[k]; j++) begin
                if (m_cells[k][s + j] != m_cells[k][s]) same = 0;
            end
            if (same) return s;
        end
        return -1;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_phase[k] = 0;
                m_n[k]     = 0;
            end else if (start) begin
                m_phase[k] = 1;
                m_n[k]     = 0;
            end else if (m_phase[k] == 1) begin
                if (in_valid) begin
                    m_cells[k][m_n[k]] = int'(piece);
                    m_n[k]++;
                    if (in_last || m_n[k] == ml[k]) m_phase[k] = 2;
                end
            end else if (m_phase[k] == 2) begin
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            int pos;
            logic [31:0] o_rdy, o_win, o_pl, o_wi, o_done;
            pos = first_run(k);
            case (k)
                0: begin o_rdy = 32'(rdy0); o_win = 32'(win0); o_pl = 32'(pl0); o_wi = 32'(wi0); o_done = 32'(done0); end
                1: begin o_rdy = 32'(rdy1); o_win = 32'(win1); o_pl = 32'(pl1); o_wi = 32'(wi1); o_done = 32'(done1); end
                default: begin o_rdy = 32'(rdy2); o_win = 32'(win2); o_pl = 32'(pl2); o_wi = 32'(wi2); o_done = 32'(done2); end
            endcase
            check($sformatf("u%0d_in_ready", k), o_rdy, 32'(m_phase[k] == 1));
            check($sformatf("u%0d_done", k), o_done, 32'(m_phase[k] == 2));
            check($sformatf("u%0d_win", k), o_win, 32'(pos >= 0));
            check($sformatf("u%0d_win_player", k), o_pl, (pos >= 0) ? 32'(m_cells[k][pos]) : 32'd0);
            check($sformatf("u%0d_win_idx", k), o_wi, (pos >= 0) ? 32'(pos) : 32'd0);
        end
    endtask

    // One clock: drive inputs, let DUTs and model take the edge, then compare.
    task automatic step(input bit s, input bit v, input bit l, input logic [1:0] p, input bit r = 1'b1);
        start    = s;
        in_valid = v;
        in_last  = l;
        piece    = p;
        reset    = r;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic feed(input int seq[], input bit last_on_end);
        foreach (seq[i]) step(1'b0, 1'b1, last_on_end && (i == seq.size() - 1), 2'(seq[i]));
    endtask

    initial begin
        logic [1:0] last_p;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; piece = '0;
        for (int k = 0; k < 3; k++) begin m_phase[k] = 0; m_n[k] = 0; end

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        check("rst_in_ready", 32'(rdy0), 32'd0);
        check("rst_win", 32'(win0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // Four reds ending on in_last.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0, 2'd1);
        check("red3_short_win", 32'(win2), 32'd1);
        check("red3_def_nowin", 32'(win0), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'd1);
        check("red4_win", 32'(win0), 32'd1);
        check("red4_player", 32'(pl0), 32'd1);
        check("red4_idx", 32'(wi0), 32'd0);
        check("red4_done", 32'(done0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);
        check("red4_done_once", 32'(done0), 32'd0);
        check("red4_win_held", 32'(win0), 32'd1);

        // Yellow win at idx 4; line ends at the last cell without in_last.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        feed('{2, 1, 1, 0, 2, 2, 2, 2}, 1'b0);
        check("full_win", 32'(win0), 32'd1);
        check("full_player", 32'(pl0), 32'd2);
        check("full_idx", 32'(wi0), 32'd4);
        check("full_done", 32'(done0), 32'd1);
        check("full_long_scanning", 32'(rdy1), 32'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // Long line: yellow wins first, later red run does not replace it.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        feed('{1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1}, 1'b1);
        check("sticky_win", 32'(win1), 32'd1);
        check("sticky_player", 32'(pl1), 32'd2);
        check("sticky_idx", 32'(wi1), 32'd3);
        check("sticky_done", 32'(done1), 32'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // Gaps between valid pieces.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, (i == 3), 2'd1);
            if (i == 2) begin
                check("gap_short_win", 32'(win2), 32'd1);
                check("gap_short_idx", 32'(wi2), 32'd0);
                check("gap_def_nowin", 32'(win0), 32'd0);
            end
            if (i < 3) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        check("gap_win", 32'(win0), 32'd1);
        check("gap_idx", 32'(wi0), 32'd0);
        check("gap_done", 32'(done0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // Restart mid-line; start beats a simultaneous valid piece.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        feed('{1, 1, 1}, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'd2);
        check("abort_no_done", 32'(done0), 32'd0);
        check("abort_short_cleared", 32'(win2), 32'd0);
        check("abort_in_ready", 32'(rdy0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 2'd1);
        check("abort_single_nowin", 32'(win2), 32'd0);
        check("abort_single_done", 32'(done0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // Reset mid-line.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        feed('{1, 1, 1, 1}, 1'b0);
        check("prerst_win", 32'(win0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        check("midrst_win", 32'(win0), 32'd0);
        check("midrst_player", 32'(pl0), 32'd0);
        check("midrst_in_ready", 32'(rdy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0);
        check("midrst_no_done", 32'(done0), 32'd0);

        // Randomised traffic biased towards runs.
        last_p = 2'd1;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] p;
            p = ($urandom_range(0, 2) != 0) ? last_p : 2'($urandom_range(0, 3));
            last_p = p;
            step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0), p, 1'($urandom_range(0, 199) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
